// File: rtl/sbox_arbiter.sv
// Shared pool of AES forward S-box lanes serving the round-state and key-schedule requesters.
// Optional op_cnt completion counter is built when SBOX_ARB_CNT_EN is defined.
module sbox_arbiter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    input  logic [127:0] st_in,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         key_valid,
    input  logic [31:0]  key_in,
    output logic         key_ready,
    output logic         key_done,
    output logic [31:0]  key_out,
`ifdef SBOX_ARB_CNT_EN
    output logic [15:0]  op_cnt,
`endif
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int ST_K   = 16 / LANES;
    localparam int KEY_K  = (LANES >= 4) ? 1 : 4 / LANES;
    localparam int CW     = (ST_K > 1) ? $clog2(ST_K) : 1;
    localparam logic [CW-1:0] ST_LAST  = CW'(ST_K - 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_K - 1);

    localparam logic [0:255][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_T[x];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_owner;     // 0: state requester, 1: key requester
    logic               r_prio;      // requester that wins the next tie, same encoding
    logic [15:0][7:0]   r_work;
    logic [15:0][7:0]   r_st_out;
    logic [3:0][7:0]    r_key_out;
    logic               r_st_done;
    logic               r_key_done;
    logic               r_busy;

    logic               w_grant_st;
    logic               w_grant_key;
    logic [CW-1:0]      w_last;
    logic [3:0]         w_base;
    logic [3:0]         w_idx [LANES];
    logic [7:0]         w_sub [LANES];

    // Handshake: a requester holds valid (and its data) until it sees ready; ready is
    // combinational and high only in IDLE for the granted side, so valid&&ready is the
    // single acceptance cycle. Data presented after that cycle is ignored.
    assign w_grant_st  = (r_state == S_IDLE) && st_valid  && (!key_valid || !r_prio);
    assign w_grant_key = (r_state == S_IDLE) && key_valid && (!st_valid  ||  r_prio);
    assign w_last      = r_owner ? KEY_LAST : ST_LAST;
    assign w_base      = 4'(int'(r_cnt) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l] = w_base + 4'(l);
        assign w_sub[l] = sbox(r_work[w_idx[l]]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_work     <= '0;
            r_st_out   <= '0;
            r_key_out  <= '0;
            r_st_done  <= 1'b0;
            r_key_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_st) begin
                        r_work  <= st_in;
                        r_owner <= 1'b0;
                        r_prio  <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end else if (w_grant_key) begin
                        r_work  <= {96'b0, key_in};
                        r_owner <= 1'b1;
                        r_prio  <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Key words occupy bytes 0-3 only; wider lanes beyond that are discarded.
                    for (int l = 0; l < LANES; l++) begin
                        if (!r_owner) begin
                            r_st_out[w_idx[l]] <= w_sub[l];
                        end else if (w_idx[l][3:2] == 2'b00) begin
                            r_key_out[w_idx[l][1:0]] <= w_sub[l];
                        end
                    end
                    if (r_cnt == w_last) begin
                        r_state    <= S_DONE;
                        r_st_done  <= !r_owner;
                        r_key_done <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_st_done  <= 1'b0;
                    r_key_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SBOX_ARB_CNT_EN
    logic [15:0] r_op_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_op_cnt <= r_op_cnt + 16'd1;
        end
    end

    assign op_cnt = r_op_cnt;
`endif

    assign st_ready  = w_grant_st;
    assign key_ready = w_grant_key;
    assign st_done   = r_st_done;
    assign key_done  = r_key_done;
    assign st_out    = r_st_out;
    assign key_out   = r_key_out;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
